// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine judge: FSM states, verdict
// encoding, digit range and credit bookkeeping helpers.
package slot_pkg;

    typedef enum logic [2:0] {SPIN, STOP1, STOP2, JUDGE, SHOW} state_t;
    typedef enum logic [1:0] {V_NONE, V_WIN, V_PAIR, V_LOSE} verdict_t;

    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    localparam logic [7:0] CREDIT_INIT = 8'd10;
    localparam logic [7:0] CREDIT_WIN  = 8'd10;
    localparam logic [7:0] CREDIT_PAIR = 8'd2;
    localparam logic [7:0] CREDIT_LOSE = 8'd1;

    // Counters can glitch to 10 while wrapping; such a read counts as 0.
    function automatic logic [3:0] sanitize(input logic [3:0] d);
        return (d > DIGIT_MAX) ? 4'd0 : d;
    endfunction

    function automatic verdict_t judge(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
        if (a == b && b == c)
            return V_WIN;
        if (a == b || b == c || a == c)
            return V_PAIR;
        return V_LOSE;
    endfunction

    function automatic logic [7:0] credit_update(input logic [7:0] c, input verdict_t v);
        logic [8:0] sum;
        sum = {1'b0, c};
        case (v)
            V_WIN:   sum = {1'b0, c} + {1'b0, CREDIT_WIN};
            V_PAIR:  sum = {1'b0, c} + {1'b0, CREDIT_PAIR};
            V_LOSE:  sum = (c == 8'd0) ? 9'd0 : {1'b0, c} - {1'b0, CREDIT_LOSE};
            default: sum = {1'b0, c};
        endcase
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising level. Release produces no pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Any sample matching the current level is a bounce: restart the run.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/slot_judge.sv
// Three-reel slot judge: freezes reels on successive presses, scores the digits
// and holds the verdict. Define SLOT_JUDGE_CREDIT_EN to add the credit counter.
module slot_judge
    import slot_pkg::*;
#(
    parameter int DB_CYCLES   = 500000,
    parameter int SHOW_CYCLES = 50000000,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] count1,
    input  logic [3:0] count2,
    input  logic [3:0] count3,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic [3:0] reel3,
    output logic [2:0] stopped,
    output logic       win,
    output logic       pair,
    output logic       lose,
`ifdef SLOT_JUDGE_CREDIT_EN
    output logic       busy,
    output logic [7:0] credits
`else
    output logic       busy
`endif
);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

    state_t           state_reg, state_next;
    verdict_t         verdict_reg, verdict_next;
    logic [2:0]       stopped_reg, stopped_next;
    logic [CNT_W-1:0] show_cnt_reg, show_cnt_next;
    logic [3:0]       count_arr [3];
    logic [3:0]       reel_q [3];
    logic             press;
    logic             start_ok;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    assign count_arr[0] = count1;
    assign count_arr[1] = count2;
    assign count_arr[2] = count3;

    // A reel tracks its counter until its stopped bit is set, including the press edge.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_reel
            logic [3:0] reel_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    reel_reg <= 4'd0;
                else if (!stopped_reg[gi])
                    reel_reg <= sanitize(count_arr[gi]);
            end
            assign reel_q[gi] = reel_reg;
        end
    endgenerate

`ifdef SLOT_JUDGE_CREDIT_EN
    logic [7:0] credits_reg, credits_next;
    assign start_ok = (credits_reg != 8'd0);
    assign credits  = credits_reg;
`else
    assign start_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= SPIN;
            verdict_reg  <= V_NONE;
            stopped_reg  <= 3'b000;
            show_cnt_reg <= '0;
`ifdef SLOT_JUDGE_CREDIT_EN
            credits_reg  <= CREDIT_INIT;
`endif
        end else begin
            state_reg    <= state_next;
            verdict_reg  <= verdict_next;
            stopped_reg  <= stopped_next;
            show_cnt_reg <= show_cnt_next;
`ifdef SLOT_JUDGE_CREDIT_EN
            credits_reg  <= credits_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        verdict_next  = verdict_reg;
        stopped_next  = stopped_reg;
        show_cnt_next = show_cnt_reg;
`ifdef SLOT_JUDGE_CREDIT_EN
        credits_next  = credits_reg;
`endif
        case (state_reg)
            SPIN: if (press && start_ok) begin
                stopped_next = 3'b001;
                state_next   = STOP1;
            end
            STOP1: if (press) begin
                stopped_next = 3'b011;
                state_next   = STOP2;
            end
            STOP2: if (press) begin
                stopped_next = 3'b111;
                state_next   = JUDGE;
            end
            JUDGE: begin
                verdict_next  = judge(reel_q[0], reel_q[1], reel_q[2]);
                show_cnt_next = SHOW_LAST;
                state_next    = SHOW;
`ifdef SLOT_JUDGE_CREDIT_EN
                credits_next  = credit_update(credits_reg, verdict_next);
`endif
            end
            SHOW: begin
                // Presses are dropped here; they are not remembered for the next game.
                if (show_cnt_reg == '0) begin
                    verdict_next = V_NONE;
                    stopped_next = 3'b000;
                    state_next   = SPIN;
                end else begin
                    show_cnt_next = show_cnt_reg - 1'b1;
                end
            end
            default: state_next = SPIN;
        endcase
    end

    assign reel1   = reel_q[0];
    assign reel2   = reel_q[1];
    assign reel3   = reel_q[2];
    assign stopped = stopped_reg;
    assign win     = (verdict_reg == V_WIN);
    assign pair    = (verdict_reg == V_PAIR);
    assign lose    = (verdict_reg == V_LOSE);
    assign busy    = (state_reg == JUDGE) || (state_reg == SHOW);

endmodule

// File: tb/tb_slot_judge.sv
// Bench for slot_judge with short debounce/show intervals; a cycle-level
// game model is compared every cycle, plus hand-computed spot values.
module tb_slot_judge;

    localparam int DB = 4;
    localparam int SH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] count1 = 4'd0, count2 = 4'd0, count3 = 4'd0;
    logic [3:0] reel1, reel2, reel3;
    logic [2:0] stopped;
    logic       win, pair, lose, busy;
`ifdef SLOT_JUDGE_CREDIT_EN
    logic [7:0] credits;
`endif

    slot_judge #(.DB_CYCLES(DB), .SHOW_CYCLES(SH), .CNT_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .count1  (count1),
        .count2  (count2),
        .count3  (count3),
        .reel1   (reel1),
        .reel2   (reel2),
        .reel3   (reel3),
        .stopped (stopped),
        .win     (win),
        .pair    (pair),
        .lose    (lose),
`ifdef SLOT_JUDGE_CREDIT_EN
        .busy    (busy),
        .credits (credits)
`else
        .busy    (busy)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: debounced level from a window of raw samples,
    // game progress as "number of frozen reels" plus judge/show phases.
    bit hist[$];
    bit m_db, m_press, m_ok;
    int m_stops, m_phase, m_left, m_verdict, m_credits, m_ones, m_eq, m_n;
    int m_reel[3];
    int m_cnt[3];

    always @(posedge clk) begin
        m_cnt[0] = count1;
        m_cnt[1] = count2;
        m_cnt[2] = count3;
        if (rst) begin
            hist = {};
            for (int j = 0; j < 6; j++) hist.push_back(1'b0);
            m_db = 0; m_press = 0; m_stops = 0; m_phase = 0; m_left = 0;
            m_verdict = 0; m_credits = 10;
            for (int j = 0; j < 3; j++) m_reel[j] = 0;
        end else begin
            case (m_phase)
                0: begin
                    for (int j = 0; j < 3; j++)
                        if (j >= m_stops) m_reel[j] = (m_cnt[j] > 9) ? 0 : m_cnt[j];
`ifdef SLOT_JUDGE_CREDIT_EN
                    m_ok = (m_stops > 0) || (m_credits > 0);
`else
                    m_ok = 1'b1;
`endif
                    if (m_press && m_ok) begin
                        m_stops++;
                        if (m_stops == 3) m_phase = 1;
                    end
                end
                1: begin
                    m_eq = 0;
                    if (m_reel[0] == m_reel[1]) m_eq++;
                    if (m_reel[1] == m_reel[2]) m_eq++;
                    if (m_reel[0] == m_reel[2]) m_eq++;
                    m_verdict = (m_eq == 3) ? 1 : (m_eq == 1) ? 2 : 3;
                    if (m_verdict == 1)      m_credits = (m_credits + 10 > 255) ? 255 : m_credits + 10;
                    else if (m_verdict == 2) m_credits = (m_credits + 2 > 255) ? 255 : m_credits + 2;
                    else                     m_credits = (m_credits == 0) ? 0 : m_credits - 1;
                    m_phase = 2;
                    m_left = SH;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_verdict = 0; m_stops = 0; m_phase = 0;
                    end
                end
            endcase
            hist.push_back(btn);
            if (hist.size() > 8) void'(hist.pop_front());
            // Two synchronizer stages delay the raw samples; DB of them decide.
            m_n = hist.size();
            m_ones = 0;
            for (int j = m_n - 6; j <= m_n - 3; j++) m_ones += int'(hist[j]);
            m_press = 0;
            if (!m_db && m_ones == DB) begin
                m_db = 1; m_press = 1;
            end else if (m_db && m_ones == 0) begin
                m_db = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("m_reel1", reel1, m_reel[0]);
            chk("m_reel2", reel2, m_reel[1]);
            chk("m_reel3", reel3, m_reel[2]);
            chk("m_stopped", stopped, (1 << m_stops) - 1);
            chk("m_win", win, m_verdict == 1);
            chk("m_pair", pair, m_verdict == 2);
            chk("m_lose", lose, m_verdict == 3);
            chk("m_busy", busy, m_phase != 0);
`ifdef SLOT_JUDGE_CREDIT_EN
            chk("m_credits", credits, m_credits);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (7) tick();
        btn = 1'b0;
        repeat (6) tick();
    endtask

    task automatic game(input int a, input int b, input int c);
        count1 = 4'(a); count2 = 4'(b); count3 = 4'(c);
        press(); press(); press();
        $display("game %0d %0d %0d: reels %0d %0d %0d win %0b pair %0b lose %0b",
                 a, b, c, reel1, reel2, reel3, win, pair, lose);
    endtask

    int n;

    initial begin
        tick(); tick();
        en = 1'b1;
        chk("rst_reels", {reel1, reel2, reel3}, 0);
        chk("rst_stopped", stopped, 0);
        chk("rst_flags", {win, pair, lose, busy}, 0);
`ifdef SLOT_JUDGE_CREDIT_EN
        chk("rst_credits", credits, 10);
`endif
        rst = 1'b0;

        // Bounce then a steady high: one press, six edges after the level settles.
        count1 = 4'd7; count2 = 4'd7; count3 = 4'd7;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            tick(); tick();
        end
        btn = 1'b1;
        repeat (6) tick();
        chk("bounce_early", stopped, 0);
        tick();
        chk("bounce_press", stopped, 1);
        repeat (10) tick();
        chk("bounce_single", stopped, 1);
        btn = 1'b0;
        repeat (6) tick();
        $display("bounce: stopped %b", stopped);

        // Win 7/7/7.
        press();
        chk("win_stop2", stopped, 3);
        btn = 1'b1;
        repeat (7) tick();
        chk("win_stop3", stopped, 7);
        chk("win_busy", busy, 1);
        btn = 1'b0;
        tick();
        chk("win_flags", {win, pair, lose}, 3'b100);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (win) n++;
            else break;
        end
        chk("win_len", n, 8);
        chk("win_end", {stopped, busy, win, pair, lose}, 0);
        $display("win game: shown %0d cycles", n);
        repeat (6) tick();

        game(3, 5, 3);
        chk("pair_flags", {win, pair, lose}, 3'b010);
        chk("pair_reels", {reel1, reel2, reel3}, {4'd3, 4'd5, 4'd3});
        repeat (10) tick();

        game(1, 2, 4);
        chk("lose_flags", {win, pair, lose}, 3'b001);
        repeat (10) tick();

        // Wrap on the freezing edge, then a press landing inside SHOW.
        count1 = 4'd4; count2 = 4'd3; count3 = 4'd0;
        press();
        count2 = 4'd10;
        press();
        chk("wrap_reel2", reel2, 0);
        btn = 1'b1; repeat (4) tick();
        btn = 1'b0; repeat (4) tick();
        btn = 1'b1; repeat (4) tick();
        btn = 1'b0;
        chk("wrap_pair", {win, pair, lose}, 3'b010);
        repeat (12) tick();
        chk("ignore_stopped", stopped, 0);
        chk("ignore_busy", busy, 0);
        $display("wrap game: reels %0d %0d %0d, show press dropped", reel1, reel2, reel3);
        count1 = 4'd9; count2 = 4'd9; count3 = 4'd2;
        press();
        chk("next_first", stopped, 1);
        press(); press();
        chk("next_pair", {win, pair, lose}, 3'b010);
        repeat (10) tick();

        // Reset in STOP2.
        count1 = 4'd5; count2 = 4'd6; count3 = 4'd7;
        press(); press();
        chk("mid_stop2", stopped, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reels", {reel1, reel2, reel3}, 0);
        chk("mid_state", {stopped, win, pair, lose, busy}, 0);
        repeat (20) tick();
        chk("mid_noverdict", {win, pair, lose, busy, stopped}, 0);
        chk("mid_track", reel1, 5);
        $display("mid-game reset: stopped %b reel1 %0d", stopped, reel1);

`ifdef SLOT_JUDGE_CREDIT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cr_init", credits, 10);
        for (int g = 0; g < 11; g++) begin
            game(1, 2, 4);
            repeat (10) tick();
            if (g == 0) chk("cr_first", credits, 9);
        end
        chk("cr_zero", credits, 0);
        press();
        chk("cr_blocked", stopped, 0);
        $display("credits: %0d", credits);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_judge.md
Name: slot_judge

Overview:
- Consumer side of the free-running reel digit counters (three decimal digits, 0–9).
- Player presses one button three times; each press freezes the next reel (1, 2, then 3).
- After the third press the block judges the frozen digits: win (all three equal), pair (exactly two equal) or lose.
- Holds the verdict for a display interval, then re-arms.
- Sits between the reel counters / button input and the display / LED drivers.

Parameters:
- DB_CYCLES, 500000, number of consecutive stable synchronized samples needed to accept a new button level.
- SHOW_CYCLES, 50000000, number of cycles the verdict is held in SHOW.
- CNT_W, 32, width of the debounce and show counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- btn  in  1  raw stop button, asynchronous to clk, active-high.
- count1  in  4  live reel-1 digit; may briefly read 10.
- count2  in  4  live reel-2 digit; same.
- count3  in  4  live reel-3 digit; same.
- reel1  out  4  displayed reel-1 digit.
- reel2  out  4  displayed reel-2 digit.
- reel3  out  4  displayed reel-3 digit.
- stopped  out  3  bit i set means reel i+1 is frozen.
- win  out  1  verdict: all three digits equal.
- pair  out  1  verdict: exactly two digits equal.
- lose  out  1  verdict: no two digits equal.
- busy  out  1  high in JUDGE and SHOW; presses are ignored while high.

Behaviour:
- Reset (synchronous, active-high; clk/rst fixed as above):
  - state = SPIN, all outputs 0, debounced level 0, counters 0, synchronizer flops 0.
- Button path:
  - btn passes through a 2-flop synchronizer.
  - Debounced level changes only after DB_CYCLES consecutive cycles at the new value. Any bounce restarts the count.
  - press = one-cycle pulse on the 0→1 edge of the debounced level. Release generates no pulse. Holding the button generates exactly one press.
- Digit sanitising: an input value ≥10 is treated as 0 wherever it is registered.
- States:
  - SPIN: reelN <= sanitised countN every cycle (1-cycle registered latency); stopped = 000. On press: reel1 keeps the value registered on that edge, stopped = 001, go to STOP1.
  - STOP1: reel1 frozen; reel2 and reel3 still track. On press: freeze reel2, stopped = 011, go to STOP2.
  - STOP2: on press: freeze reel3, stopped = 111, go to JUDGE.
  - JUDGE: one cycle. Compute the verdict from reel1..3 and register exactly one of win/pair/lose. Go to SHOW and load the show counter.
  - SHOW: hold reels, stopped and verdict for SHOW_CYCLES cycles. Then clear the verdict and stopped, and return to SPIN. Reels resume tracking on the next cycle.
- busy = 1 in JUDGE and SHOW. A press in these states is discarded, not queued.
- Verdict flags are mutually exclusive and are 0 outside SHOW.
- rst asserted in any state: block returns to the reset values on the next edge, the in-progress game is abandoned, and no verdict is emitted.

Optional Feature:
- Macro SLOT_JUDGE_CREDIT_EN.
- Defined:
  - Adds output port credits [7:0], reset value 10.
  - Updated on JUDGE exit: win +10, pair +2, lose −1.
  - Saturates at 255 and at 0.
  - While credits == 0, a press in SPIN is ignored (the game cannot start). Presses in STOP1/STOP2 are still honoured.
- Undefined: no credits port and no credit logic; any press in SPIN starts a game.

Decomposition:
- Package slot_pkg holds:
  - the state enum (SPIN, STOP1, STOP2, JUDGE, SHOW);
  - DIGIT_MAX = 9;
  - the verdict encoding;
  - the credit constants (init 10, win +10, pair +2, lose −1).
- One sub-module, btn_debounce: synchronizer, stability counter and rising-edge pulse, parameterised by DB_CYCLES. Reused for future buttons.

Test Plan:
- Bench parameters: DB_CYCLES = 4, SHOW_CYCLES = 8.
- Bounce: btn toggles every 2 cycles for 20 cycles, then held high → exactly one press pulse, asserted 2 + 4 cycles after the stable high. stopped goes 000→001.
- Win: counts held at 7/7/7, three clean presses → stopped steps 001, 011, 111. win = 1 (pair = lose = 0) for exactly 8 cycles, then all flags 0 and state SPIN.
- Pair and lose: pair case freezes digits 3, 5, 3 → pair = 1. Lose case freezes 1, 2, 4 → lose = 1.
- Wrap and ignore: count2 = 10 on the freezing edge → reel2 = 0. An extra press during SHOW → no effect, and the next game still needs three presses.
- Mid-game reset: rst for 1 cycle in STOP2 → reels, stopped and flags all 0 next cycle; no verdict appears.
- SLOT_JUDGE_CREDIT_EN: 11 lose games from reset → credits reach 0 and stay 0. A further press in SPIN leaves stopped = 000.
